// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_pkg
// Brief  : Op encodings, FSM state type and op classification for mc_alu.
//          ALU_DIV_EN turns DIVU/REMU into multicycle ops.
// Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_SLTU  = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MUL   = 4'b1000;
   localparam logic [3:0] OP_MULHU = 4'b1001;
   localparam logic [3:0] OP_DIVU  = 4'b1010;
   localparam logic [3:0] OP_REMU  = 4'b1011;
   localparam logic [3:0] OP_NOR   = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_DIV_EN
      return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
`else
      return (op == OP_MUL) || (op == OP_MULHU);
`endif
   endfunction

endpackage
`default_nettype wire

// File: rtl/cla_adder.sv
`default_nettype none
// ============================================================================
// Module : cla_adder
// Brief  : Parametrised parallel-prefix (lookahead) adder with carry in/out.
// Rev    : 1.0  initial release
// ============================================================================
module cla_adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int LEVELS = $clog2(WIDTH);

   logic [WIDTH-1:0] p_w;
   logic [WIDTH-1:0] gp_w;
   logic [WIDTH-1:0] pp_w;

   // cin is folded into bit 0's generate, so gp_w[i] ends as the carry out of bit i
   always_comb begin
      p_w     = a ^ b;
      gp_w    = a & b;
      gp_w[0] = gp_w[0] | (p_w[0] & cin);
      pp_w    = p_w;
      for (int l = 0; l < LEVELS; l++) begin
         gp_w = gp_w | (pp_w & (gp_w << (1 << l)));
         pp_w = pp_w & (pp_w << (1 << l));
      end
   end

   assign sum  = p_w ^ {gp_w[WIDTH-2:0], cin};
   assign cout = gp_w[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/mc_alu.sv
`default_nettype none
// ============================================================================
// Module : mc_alu
// Brief  : Multicycle MIPS ALU with valid/ready handshake, iterative multiply
//          and, when ALU_DIV_EN is defined, iterative restoring divide.
// Rev    : 1.0  initial release
// ============================================================================
module mc_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow
);

   localparam int            CW        = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               hisel_q, hisel_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;

   logic               accept_w, sub_w, cout_w, ovf_w, slt_w;
   logic [WIDTH-1:0]   bx_w, sum_w, sc_res_w, final_w;
   logic               sc_carry_w, sc_ovf_w;
   logic [WIDTH:0]     madd_w;
   logic [2*WIDTH-1:0] step_w;

   // SUB, SLT and SLTU all evaluate a + ~b + 1
   assign sub_w = (alu_control != OP_ADD);
   assign bx_w  = sub_w ? ~b : b;

   cla_adder #(.WIDTH(WIDTH)) u_cla (
      .a    (a),
      .b    (bx_w),
      .cin  (sub_w),
      .sum  (sum_w),
      .cout (cout_w)
   );

   assign ovf_w = (a[WIDTH-1] == bx_w[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
   assign slt_w = sum_w[WIDTH-1] ^ ovf_w;

   always_comb begin
      sc_res_w   = '0;
      sc_carry_w = 1'b0;
      sc_ovf_w   = 1'b0;
      case (alu_control)
         OP_AND:  sc_res_w = a & b;
         OP_OR:   sc_res_w = a | b;
         OP_XOR:  sc_res_w = a ^ b;
         OP_NOR:  sc_res_w = ~(a | b);
         OP_ADD, OP_SUB: begin
            sc_res_w   = sum_w;
            sc_carry_w = cout_w;
            sc_ovf_w   = ovf_w;
         end
         OP_SLTU: sc_res_w = {{(WIDTH-1){1'b0}}, ~cout_w};
         OP_SLT:  sc_res_w = {{(WIDTH-1){1'b0}}, slt_w};
         default: sc_res_w = '0;
      endcase
   end

   // acc_q = {partial product | partial remainder, multiplier | dividend->quotient}
   assign madd_w = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

`ifdef ALU_DIV_EN
   logic           div_q, div_d;
   logic [WIDTH:0] dshift_w;
   logic           dge_w;

   assign dshift_w = acc_q[2*WIDTH-1:WIDTH-1];
   assign dge_w    = (dshift_w >= {1'b0, opb_q});

   always_comb begin
      if (div_q) begin
         step_w = {(dge_w ? dshift_w[WIDTH-1:0] - opb_q : dshift_w[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], dge_w};
      end else begin
         step_w = {madd_w, acc_q[WIDTH-1:1]};
      end
   end
`else
   assign step_w = {madd_w, acc_q[WIDTH-1:1]};
`endif

   // MULHU and REMU (op bit 0 set) take the upper half of the accumulator
   assign final_w = hisel_q ? step_w[2*WIDTH-1:WIDTH] : step_w[WIDTH-1:0];

   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept_w = in_valid && in_ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opb_d    = opb_q;
      hisel_d  = hisel_q;
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
`ifdef ALU_DIV_EN
      div_d    = div_q;
`endif
      case (state_q)
         BUSY: begin
            acc_d = step_w;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_ITER) begin
               state_d  = DONE;
               result_d = final_w;
               zero_d   = (final_w == '0);
               carry_d  = 1'b0;
               ovf_d    = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = state_q;
      endcase

      if (accept_w) begin
         if (is_multicycle(alu_control)) begin
            state_d = BUSY;
            cnt_d   = '0;
            acc_d   = {{WIDTH{1'b0}}, a};
            opb_d   = b;
            hisel_d = alu_control[0];
`ifdef ALU_DIV_EN
            div_d   = alu_control[1];
`endif
         end else begin
            state_d  = DONE;
            result_d = sc_res_w;
            zero_d   = (sc_res_w == '0);
            carry_d  = sc_carry_w;
            ovf_d    = sc_ovf_w;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         hisel_q  <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef ALU_DIV_EN
         div_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opb_q    <= opb_d;
         hisel_q  <= hisel_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
`ifdef ALU_DIV_EN
         div_q    <= div_d;
`endif
      end
   end

   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign overflow  = ovf_q;

endmodule
`default_nettype wire
